// File: rtl/rot_sched_ctrl.sv
// Iterative controller for the 8-lane byte-rotation network: runs ROUNDS rotation
// rounds on a 64-bit word, feeding each network result back, then hands it off over valid/ready.
module rot_sched_ctrl #(
   parameter int ROUNDS = 4,
   parameter int LAT    = 1
) (
   input  logic                  clk1,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_r1,
   input  logic [31:0]           in_r2,
   input  logic [3*ROUNDS-1:0]   in_sched,
   input  logic                  abort,
   output logic                  sm_en,
   output logic [2:0]            sm_sel,
   output logic [31:0]           sm_r1,
   output logic [31:0]           sm_r2,
   input  logic [63:0]           sm_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [63:0]           out_data,
   output logic                  busy,
   output logic [2:0]            round_idx
);

   typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

   localparam logic [1:0] LAT_CNT    = 2'(LAT);
   localparam logic [2:0] LAST_ROUND = 3'(ROUNDS - 1);

   state_t                state_reg, state_next;
   logic [63:0]           data_reg, data_next;
   logic [3*ROUNDS-1:0]   sched_reg, sched_next;
   logic [2:0]            round_reg, round_next;
   logic [1:0]            cnt_reg, cnt_next;
   logic [2:0]            sched_arr [0:7];

   // Pad unused schedule slots so round_reg can index a fixed 8-entry table.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_sched
         if (gi < ROUNDS) begin : g_used
            assign sched_arr[gi] = sched_reg[3*gi +: 3];
         end else begin : g_pad
            assign sched_arr[gi] = 3'd0;
         end
      end
   endgenerate

   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         data_reg  <= '0;
         sched_reg <= '0;
         round_reg <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         data_reg  <= data_next;
         sched_reg <= sched_next;
         round_reg <= round_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      data_next  = data_reg;
      sched_next = sched_reg;
      round_next = round_reg;
      cnt_next   = cnt_reg;
      in_ready   = 1'b0;
      sm_en      = 1'b0;
      sm_sel     = 3'd0;
      sm_r1      = 32'd0;
      sm_r2      = 32'd0;
      out_valid  = 1'b0;
      out_data   = 64'd0;

      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               data_next  = {in_r1, in_r2};
               sched_next = in_sched;
               round_next = 3'd0;
               cnt_next   = 2'd0;
               state_next = ROT;
            end
         end

         ROT: begin
            sm_en  = 1'b1;
            sm_sel = sched_arr[round_reg];
            sm_r1  = data_reg[63:32];
            sm_r2  = data_reg[31:0];
            if (abort) begin
               round_next = 3'd0;
               cnt_next   = 2'd0;
               state_next = IDLE;
            end else if (cnt_reg == LAT_CNT) begin
               // Network inputs have been stable for LAT cycles, so sm_out is valid.
               data_next = sm_out;
               cnt_next  = 2'd0;
               if (round_reg == LAST_ROUND) begin
                  state_next = DONE;
               end else begin
                  round_next = round_reg + 3'd1;
               end
            end else begin
               cnt_next = cnt_reg + 2'd1;
            end
         end

         DONE: begin
            out_valid = 1'b1;
            out_data  = data_reg;
            if (abort || out_ready) begin
               round_next = 3'd0;
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy      = (state_reg != IDLE);
   assign round_idx = round_reg;

endmodule

// File: tb/tb_rot_sched_ctrl.sv
// Directed bench for rot_sched_ctrl: a registered rotation-network model closes the loop,
// results are checked by a queue-based scoreboard monitor, control behaviour inline.
module tb_rot_sched_ctrl;

   localparam int ROUNDS = 4;
   localparam int LAT    = 1;

   logic                clk1 = 1'b0;
   logic                rst_n;
   logic                in_valid;
   logic                in_ready;
   logic [31:0]         in_r1;
   logic [31:0]         in_r2;
   logic [3*ROUNDS-1:0] in_sched;
   logic                abort;
   logic                sm_en;
   logic [2:0]          sm_sel;
   logic [31:0]         sm_r1;
   logic [31:0]         sm_r2;
   logic [63:0]         sm_out = 64'd0;
   logic                out_valid;
   logic                out_ready;
   logic [63:0]         out_data;
   logic                busy;
   logic [2:0]          round_idx;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [63:0] exp_q [$];

   int          en_cnt    = 0;
   logic [23:0] trace_sel = '0;
   logic [23:0] trace_rnd = '0;

   rot_sched_ctrl #(.ROUNDS(ROUNDS), .LAT(LAT)) dut (
      .clk1      (clk1),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_r1     (in_r1),
      .in_r2     (in_r2),
      .in_sched  (in_sched),
      .abort     (abort),
      .sm_en     (sm_en),
      .sm_sel    (sm_sel),
      .sm_r1     (sm_r1),
      .sm_r2     (sm_r2),
      .sm_out    (sm_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .round_idx (round_idx)
   );

   always #5 clk1 = ~clk1;

   function automatic logic [63:0] rotl(input logic [63:0] w, input logic [2:0] s);
      int sh;
      sh = 8 * int'(s);
      if (sh == 0) return w;
      return (w << sh) | (w >> (64 - sh));
   endfunction

   // Network model: registered byte rotate-left, one cycle of latency.
   always @(posedge clk1) sm_out <= rotl({sm_r1, sm_r2}, sm_sel);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Per-job trace of network-driving cycles, cleared on every accept.
   always @(negedge clk1) begin
      if (in_valid && in_ready) begin
         en_cnt    <= 0;
         trace_sel <= '0;
         trace_rnd <= '0;
      end else if (sm_en) begin
         en_cnt    <= en_cnt + 1;
         trace_sel <= {trace_sel[20:0], sm_sel};
         trace_rnd <= {trace_rnd[20:0], round_idx};
      end
   end

   // Scoreboard monitor: one comparison per completed output handshake.
   always @(negedge clk1) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_result: got %h with no expected entry", out_data);
         end else begin
            chk("out_data", out_data, exp_q.pop_front());
         end
         $display("result handshake: out_data=%h", out_data);
      end
   end

   task automatic start_job(input logic [31:0] r1, input logic [31:0] r2,
                            input logic [3*ROUNDS-1:0] s, input logic ab);
      @(posedge clk1);
      #1;
      in_valid = 1'b1;
      in_r1    = r1;
      in_r2    = r2;
      in_sched = s;
      abort    = ab;
      @(posedge clk1);
      #1;
      in_valid = 1'b0;
      abort    = 1'b0;
      $display("job offered: r1=%h r2=%h sched=%o abort=%0b", r1, r2, s, ab);
   endtask

   // Counts cycles from the accept cycle (cycle 0) to the first out_valid cycle.
   task automatic wait_valid(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk1);
         n++;
      end while (!out_valid && n < 40);
      chk(name, 64'(n), 64'd9);
   endtask

   task automatic drain();
      for (int i = 0; i < 6 && exp_q.size() != 0; i++) @(negedge clk1);
   endtask

   task automatic wait_round(input logic [2:0] r);
      for (int i = 0; i < 30 && !(sm_en && round_idx == r); i++) @(negedge clk1);
      chk("reach_round", {61'd0, round_idx}, {61'd0, r});
   endtask

   task automatic chk_idle_reset(input string name);
      chk(name, {54'd0, in_ready, busy, out_valid, sm_en, sm_sel, round_idx},
          {54'd0, 10'b10_0000_0000});
      chk({name, "_data"}, out_data, 64'd0);
      chk({name, "_sm_r"}, {sm_r1, sm_r2}, 64'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_r1     = '0;
      in_r2     = '0;
      in_sched  = '0;
      abort     = 1'b0;
      out_ready = 1'b1;
      @(posedge clk1);
      @(negedge clk1);
      chk_idle_reset("reset_state");
      @(posedge clk1);
      #1 rst_n = 1'b1;

      // 1: pass-through schedule
      exp_q.push_back(64'h0011223344556677);
      start_job(32'h00112233, 32'h44556677, 12'o0000, 1'b0);
      wait_valid("t1_latency");
      chk("t1_en_cycles", 64'(en_cnt), 64'd8);
      drain();

      // 2: rotate by one byte every round
      exp_q.push_back(64'h4455667700112233);
      start_job(32'h00112233, 32'h44556677, 12'o1111, 1'b0);
      wait_valid("t2_latency");
      chk("t2_sel_trace", {40'd0, trace_sel}, {40'd0, 24'o11111111});
      drain();

      // 3: round0=1, round1=2, rest pass-through
      exp_q.push_back(64'h3344556677001122);
      start_job(32'h00112233, 32'h44556677, 12'o0021, 1'b0);
      wait_valid("t3_latency");
      chk("t3_sel_trace", {40'd0, trace_sel}, {40'd0, 24'o11220000});
      chk("t3_round_trace", {40'd0, trace_rnd}, {40'd0, 24'o00112233});
      drain();

      // 4: consumer backpressure for five cycles
      #1 out_ready = 1'b0;
      exp_q.push_back(64'h2233445566770011);
      start_job(32'h00112233, 32'h44556677, 12'o0002, 1'b0);
      wait_valid("t4_latency");
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk1);
         chk("t4_hold_valid", {63'd0, out_valid}, 64'd1);
         chk("t4_hold_data", out_data, 64'h2233445566770011);
         chk("t4_in_ready_low", {63'd0, in_ready}, 64'd0);
      end
      @(posedge clk1);
      #1 out_ready = 1'b1;
      @(negedge clk1);
      @(negedge clk1);
      chk("t4_idle_after_hs", {61'd0, in_ready, busy, out_valid}, {61'd0, 3'b100});
      chk("t4_popped", 64'(exp_q.size()), 64'd0);

      // 5: reset during round 2, then a fresh job
      start_job(32'h00112233, 32'h44556677, 12'o1111, 1'b0);
      wait_round(3'd2);
      @(posedge clk1);
      #1 rst_n = 1'b0;
      @(posedge clk1);
      #1 rst_n = 1'b1;
      @(negedge clk1);
      chk_idle_reset("t5_after_reset");
      exp_q.push_back(64'h456789abcdef0123);
      start_job(32'h01234567, 32'h89abcdef, 12'o4321, 1'b0);
      wait_valid("t5_latency");
      drain();

      // 6: abort in round 1 with the next job already offered
      start_job(32'h00112233, 32'h44556677, 12'o0021, 1'b0);
      wait_round(3'd1);
      @(posedge clk1);
      #1;
      abort    = 1'b1;
      in_valid = 1'b1;
      in_r1    = 32'hdeadbeef;
      in_r2    = 32'h01234567;
      in_sched = 12'o1753;
      exp_q.push_back(64'hdeadbeef01234567);
      @(posedge clk1);
      #1 abort = 1'b0;
      @(negedge clk1);
      chk("t6_idle_after_abort", {61'd0, in_ready, busy, out_valid}, {61'd0, 3'b100});
      @(posedge clk1);
      #1 in_valid = 1'b0;
      $display("job offered after abort: r1=deadbeef r2=01234567 sched=1753");
      wait_valid("t6_latency");
      drain();

      // 7: abort asserted in IDLE alongside an accept is ignored
      exp_q.push_back(64'h0011223344556677);
      start_job(32'h00112233, 32'h44556677, 12'o0044, 1'b1);
      wait_valid("t7_latency");
      drain();

      repeat (3) @(negedge clk1);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation timeout");
   end

endmodule
